// File: rtl/ls165_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ls165_pkg
//  Description : Shared definitions for the LS165 serial reader: default frame
//                width and shift-clock divider, plus the reader FSM encoding.
//  Contents    : LS165_WIDTH_DEF - default bits per frame (one LS165)
//                LS165_DIV_DEF   - default system clocks per shift-clock phase
//                state_t         - reader FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package ls165_pkg;

    localparam int LS165_WIDTH_DEF = 8;
    localparam int LS165_DIV_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

endpackage : ls165_pkg
`default_nettype wire

// File: rtl/ls165_tick.sv
`default_nettype none
// ============================================================================
//  Module      : ls165_tick
//  Description : Phase divider for the LS165 reader. Counts 0..DIV-1 and
//                flags the last cycle of each phase. The count restarts from
//                0 whenever the reader FSM changes state, so every phase
//                begins aligned with its state entry.
//  Ports       : cp          - system clock (rising edge)
//                mr_         - asynchronous active-low reset
//                restart_i   - FSM is changing state on this edge
//                phase_end_o - current cycle is the last of the phase
//  Revision    : 1.0 - initial release
// ============================================================================
module ls165_tick #(
    parameter int DIV = 2
) (
    input  logic cp,
    input  logic mr_,
    input  logic restart_i,
    output logic phase_end_o
);

    // A one-bit counter is kept for DIV=1; it simply never leaves 0.
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign phase_end_o = (cnt_q == CNT_LAST);

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ls165_tick
`default_nettype wire

// File: rtl/ls165_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ls165_reader
//  Description : Reads a WIDTH-bit frame from one to four chained 74LS165
//                parallel-in/serial-out registers. A start request loads the
//                parts, then WIDTH bits are clocked out MSB first and the
//                completed word is offered on a valid/ready handshake.
//  Ports       : cp     - system clock (rising edge)
//                mr_    - asynchronous active-low master reset
//                start  - capture request, sampled only while idle
//                sdi    - serial data from Q7 of the last LS165
//                pl_    - parallel-load strobe, active-low
//                scp    - shift clock to LS165 cp1
//                ce_    - clock enable to LS165 cp2, active-low
//                busy   - a frame is in progress or awaiting acceptance
//                dout   - captured word, first received bit in the MSB
//                dvalid - dout holds a word not yet accepted
//                dready - consumer accepts dout
//  Revision    : 1.0 - initial release
// ============================================================================
module ls165_reader
    import ls165_pkg::*;
#(
    parameter int WIDTH = LS165_WIDTH_DEF,
    parameter int DIV   = LS165_DIV_DEF
) (
    input  logic             cp,
    input  logic             mr_,
    input  logic             start,
    input  logic             sdi,
    output logic             pl_,
    output logic             scp,
    output logic             ce_,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             dready
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             phase_end;
    logic [WIDTH-1:0] word_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [BW-1:0]    bit_cnt_inc;
    logic             pl_q;
    logic             scp_q;
    logic             ce_q;
    logic             busy_q;
    logic             dvalid_q;
    logic [WIDTH-1:0] dout_q;

    ls165_tick #(
        .DIV (DIV)
    ) u_tick (
        .cp          (cp),
        .mr_         (mr_),
        .restart_i   (state_d != state_q),
        .phase_end_o (phase_end)
    );

    assign bit_cnt_inc = bit_cnt_q + BW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)     state_d = ST_LOAD;
            ST_LOAD:   if (phase_end) state_d = ST_SETTLE;
            ST_SETTLE: if (phase_end) state_d = ST_HIGH;
            ST_HIGH:   if (phase_end) state_d = ST_LOW;
            ST_LOW: begin
                if (phase_end) begin
                    state_d = (bit_cnt_inc == BIT_LAST) ? ST_HOLD : ST_HIGH;
                end
            end
            ST_HOLD:   if (dvalid_q && dready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobe outputs are decoded from the next state so that each one is a
    // flop output aligned exactly with the state it belongs to.
    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            bit_cnt_q <= '0;
            pl_q      <= 1'b1;
            scp_q     <= 1'b0;
            ce_q      <= 1'b1;
            busy_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q <= state_d;
            pl_q    <= (state_d != ST_LOAD);
            scp_q   <= (state_d == ST_HIGH);
            ce_q    <= !((state_d == ST_SETTLE) || (state_d == ST_HIGH) ||
                         (state_d == ST_LOW));
            busy_q  <= (state_d != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        word_q    <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                // The first bit is already on Q7 after the load, so it is
                // taken before any shift clock is issued.
                ST_SETTLE: begin
                    if (phase_end) begin
                        word_q    <= {word_q[WIDTH-2:0], sdi};
                        bit_cnt_q <= BW'(1);
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        word_q    <= {word_q[WIDTH-2:0], sdi};
                        bit_cnt_q <= bit_cnt_inc;
                    end
                end
                // dout is written once on HOLD entry and then frozen until
                // the consumer takes it.
                ST_HOLD: begin
                    if (!dvalid_q) begin
                        dout_q   <= word_q;
                        dvalid_q <= 1'b1;
                    end else if (dready) begin
                        dvalid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pl_    = pl_q;
    assign scp    = scp_q;
    assign ce_    = ce_q;
    assign busy   = busy_q;
    assign dvalid = dvalid_q;
    assign dout   = dout_q;

endmodule : ls165_reader
`default_nettype wire

// File: tb/tb_ls165_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls165_reader
//  Description : Testbench for ls165_reader. One instance (8 bits, DIV=2)
//                reads a single LS165 model; a second instance (16 bits,
//                DIV=1) reads two chained LS165 models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ls165_reader;

    localparam int W8  = 8;
    localparam int D8  = 2;
    localparam int W16 = 16;
    localparam int D16 = 1;
    localparam int LAT8  = (2 + 2 * (W8 - 1)) * D8 + 1;
    localparam int LAT16 = (2 + 2 * (W16 - 1)) * D16 + 1;

    logic cp = 1'b0;
    always #5 cp = ~cp;

    logic        mr_;
    logic        start8, dready8, sdi8, pl8_, scp8, ce8_, busy8, dvalid8;
    logic [7:0]  dout8;
    logic        start16, dready16, sdi16, pl16_, scp16, ce16_, busy16, dvalid16;
    logic [15:0] dout16;

    ls165_reader #(.WIDTH(W8), .DIV(D8)) u_dut8 (
        .cp(cp), .mr_(mr_), .start(start8), .sdi(sdi8), .pl_(pl8_),
        .scp(scp8), .ce_(ce8_), .busy(busy8), .dout(dout8),
        .dvalid(dvalid8), .dready(dready8)
    );

    ls165_reader #(.WIDTH(W16), .DIV(D16)) u_dut16 (
        .cp(cp), .mr_(mr_), .start(start16), .sdi(sdi16), .pl_(pl16_),
        .scp(scp16), .ce_(ce16_), .busy(busy16), .dout(dout16),
        .dvalid(dvalid16), .dready(dready16)
    );

    // Behavioural LS165: load while PL low, shift toward Q7 on a rising
    // cp1 with cp2 (ce_) low.
    logic [7:0] par8;
    logic [7:0] sr8;
    always @(negedge pl8_ or posedge scp8) begin
        if (!pl8_)      sr8 <= par8;
        else if (!ce8_) sr8 <= {sr8[6:0], 1'b0};
    end
    assign sdi8 = sr8[7];

    // Two chained parts: chip A (low byte) feeds DS of chip B, whose Q7
    // drives the reader.
    logic [15:0] par16;
    logic [7:0]  chip_a, chip_b;
    always @(negedge pl16_ or posedge scp16) begin
        if (!pl16_) begin
            chip_b <= par16[15:8];
            chip_a <= par16[7:0];
        end else if (!ce16_) begin
            chip_b <= {chip_b[6:0], chip_a[7]};
            chip_a <= {chip_a[6:0], 1'b0};
        end
    end
    assign sdi16 = chip_b[7];

    int pl8_n   = 0;
    int scp8_n  = 0;
    int scp16_n = 0;
    always @(negedge pl8_)  pl8_n   <= pl8_n + 1;
    always @(posedge scp8)  scp8_n  <= scp8_n + 1;
    always @(posedge scp16) scp16_n <= scp16_n + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    // Pulse start for one edge, then count edges until dvalid is seen.
    task automatic frame8(input logic [7:0] val, output int lat);
        par8   = val;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 0;
        while (!dvalid8 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          base;
        int          n;
        logic [7:0]  v8;
        logic [15:0] exp16;

        mr_ = 1'b0; start8 = 1'b0; dready8 = 1'b0; start16 = 1'b0;
        dready16 = 1'b0; par8 = '0; par16 = '0;
        step();
        step();
        check("rst_pl",     {31'd0, pl8_},   32'd1);
        check("rst_scp",    {31'd0, scp8},   32'd0);
        check("rst_ce",     {31'd0, ce8_},   32'd1);
        check("rst_busy",   {31'd0, busy8},  32'd0);
        check("rst_dvalid", {31'd0, dvalid8},32'd0);
        check("rst_dout",   {24'd0, dout8},  32'd0);
        check("rst16_ctl",  {28'd0, pl16_, scp16, ce16_, busy16}, 32'b1010);
        check("rst16_dout", {16'd0, dout16}, 32'd0);
        mr_ = 1'b1;
        step(); step(); step();
        check("idle_after_rst", {31'd0, busy8}, 32'd0);

        // Basic frame, consumer always ready (also dready high while idle).
        dready8 = 1'b1;
        base = scp8_n;
        frame8(8'hA5, lat);
        check("a5_latency", lat, LAT8);
        check("a5_dout", {24'd0, dout8}, 32'h0000_00A5);
        check("a5_scp_edges", scp8_n - base, W8 - 1);
        step();
        check("a5_released", {30'd0, dvalid8, busy8}, 32'd0);

        // Back-pressure: word must be held while dready is low.
        dready8 = 1'b0;
        frame8(8'h3C, lat);
        check("3c_latency", lat, LAT8);
        for (int i = 0; i < 20; i++) begin
            step();
            check("3c_hold", {23'd0, dvalid8, dout8}, {23'd0, 1'b1, 8'h3C});
        end
        dready8 = 1'b1;
        step();
        check("3c_released", {30'd0, dvalid8, busy8}, 32'd0);

        // Random words with random acceptance delay.
        for (int f = 0; f < 4; f++) begin
            v8 = 8'($urandom);
            dready8 = 1'b0;
            frame8(v8, lat);
            check("rnd_latency", lat, LAT8);
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) step();
            check("rnd_dout", {23'd0, dvalid8, dout8}, {23'd0, 1'b1, v8});
            dready8 = 1'b1;
            step();
            check("rnd_released", {30'd0, dvalid8, busy8}, 32'd0);
        end

        // Stray start pulses in LOAD, LOW and HOLD must not add frames.
        dready8 = 1'b0;
        base = pl8_n;
        v8 = 8'($urandom);
        par8 = v8;
        start8 = 1'b1; step(); start8 = 1'b0;
        start8 = 1'b1; step(); start8 = 1'b0;
        n = 0;
        while (scp8 !== 1'b1 && n < 100) begin step(); n++; end
        while (scp8 !== 1'b0 && n < 100) begin step(); n++; end
        start8 = 1'b1; step(); start8 = 1'b0;
        n = 0;
        while (!dvalid8 && n < 200) begin step(); n++; end
        start8 = 1'b1; step(); start8 = 1'b0;
        check("stray_dout", {23'd0, dvalid8, dout8}, {23'd0, 1'b1, v8});
        dready8 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("stray_pl_count", pl8_n - base, 1);
        check("stray_idle", {31'd0, busy8}, 32'd0);

        // Abort during the fourth HIGH phase.
        base = scp8_n;
        par8 = 8'h5A;
        start8 = 1'b1; step(); start8 = 1'b0;
        n = 0;
        while (!((scp8_n - base == 4) && scp8 === 1'b1) && n < 200) begin
            step();
            n++;
        end
        check("abort_reached_high4", scp8_n - base, 4);
        mr_ = 1'b0;
        #1;
        check("abort_outputs", {28'd0, pl8_, scp8, dvalid8, busy8}, 32'b1000);
        check("abort_ce_dout", {23'd0, ce8_, dout8}, {23'd0, 1'b1, 8'h00});
        step();
        mr_ = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("abort_stays_idle", {31'd0, busy8}, 32'd0);
        frame8(8'hFF, lat);
        check("ff_latency", lat, LAT8);
        check("ff_dout", {24'd0, dout8}, 32'h0000_00FF);

        // Chained 16-bit reader, start held high, back-to-back frames.
        exp16 = 16'h1234;
        par16 = exp16;
        dready16 = 1'b1;
        start16 = 1'b1;
        base = scp16_n;
        for (int f = 0; f < 6; f++) begin
            n = 0;
            while (!dvalid16 && n < 200) begin step(); n++; end
            check("w16_interval", n, LAT16 + 1);
            check("w16_dout", {16'd0, dout16}, {16'd0, exp16});
            check("w16_scp_edges", scp16_n - base, W16 - 1);
            base = scp16_n;
            if (f >= 2) begin
                exp16 = 16'($urandom);
                par16 = exp16;
            end
            step();
            check("w16_released", {30'd0, dvalid16, busy16}, 32'd0);
        end
        start16 = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ls165_reader
`default_nettype wire
